// File: rtl/sine_pkg.sv
// Shared constants for the sine phase generator: default widths, divider ratio
// and the FSM state encoding.
package sine_pkg;

    localparam int unsigned PHASE_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF  = 6;
    localparam int unsigned TICK_DIV_DEF    = 100;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

endpackage

// File: rtl/tick_gen.sv
// Sample-rate divider: asserts tick on the last count of every TICK_DIV-cycle
// window while enabled; the count is held at zero when disabled or cleared.
module tick_gen
    import sine_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    assign tick = enable && !clear && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sine_phase_gen.sv
// DDS-style phase accumulator that drives a registered sine table with one
// read per divider tick, with phase-continuous retuning and stop-at-wrap.
module sine_phase_gen
    import sine_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] ftw,
    input  logic                   ftw_load,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   sample_valid,
    output logic                   period_pulse,
    output logic                   busy
);

    logic [1:0]             state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] ftw_active_q, ftw_active_d;
    logic [PHASE_WIDTH-1:0] ftw_pending_q, ftw_pending_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                   rom_en_q, rom_en_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   period_pulse_q, period_pulse_d;
    logic                   busy_q, busy_d;
    logic                   last_q, last_d;

    logic                   tick;
    logic                   carry;
    logic [PHASE_WIDTH-1:0] phase_sum;
    logic                   div_enable;
    logic                   div_clear;

    assign div_enable = (state_q != ST_IDLE);
    assign div_clear  = (state_q == ST_IDLE) && start;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (div_enable),
        .clear  (div_clear),
        .tick   (tick)
    );

    assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, ftw_active_q};

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        ftw_active_d   = ftw_active_q;
        ftw_pending_d  = ftw_pending_q;
        rom_addr_d     = rom_addr_q;
        rom_en_d       = 1'b0;
        period_pulse_d = 1'b0;
        sample_valid_d = rom_en_q;
        last_d         = 1'b0;

        if (ftw_load) begin
            ftw_pending_d = ftw;
        end

        if (tick) begin
            rom_en_d       = 1'b1;
            rom_addr_d     = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
            phase_d        = phase_sum;
            period_pulse_d = carry;
            if (carry) begin
                ftw_active_d = ftw_pending_q;
            end
        end

        // The final sample is issued from STOPPING; last_q holds the FSM there one
        // more cycle so rom_en never coincides with IDLE.
        case (state_q)
            ST_IDLE: begin
                if (ftw_load) begin
                    ftw_active_d = ftw;
                end
                if (start) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                end else if (start && !stop) begin
                    state_d = ST_RUN;
                end else if (tick && (carry || (ftw_active_q == '0))) begin
                    last_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            ftw_active_q   <= '0;
            ftw_pending_q  <= '0;
            rom_addr_q     <= '0;
            rom_en_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            period_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            ftw_active_q   <= ftw_active_d;
            ftw_pending_q  <= ftw_pending_d;
            rom_addr_q     <= rom_addr_d;
            rom_en_q       <= rom_en_d;
            sample_valid_q <= sample_valid_d;
            period_pulse_q <= period_pulse_d;
            busy_q         <= busy_d;
            last_q         <= last_d;
        end
    end

    assign rom_en       = rom_en_q;
    assign rom_addr     = rom_addr_q;
    assign sample_valid = sample_valid_q;
    assign period_pulse = period_pulse_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Scoreboard bench for sine_phase_gen at PHASE_WIDTH=8, ADDR_WIDTH=6, TICK_DIV=4.
module tb_sine_phase_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] ftw = '0;
    logic       ftw_load = 1'b0;
    logic       rom_en;
    logic [5:0] rom_addr;
    logic       sample_valid;
    logic       period_pulse;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [6:0]  exp_q[$];
    logic        prev_en = 1'b0;

    sine_phase_gen #(
        .PHASE_WIDTH (8),
        .ADDR_WIDTH  (6),
        .TICK_DIV    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .ftw          (ftw),
        .ftw_load     (ftw_load),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .sample_valid (sample_valid),
        .period_pulse (period_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected sample entry: {period_pulse, rom_addr}
    task automatic push_range(input int from, input int to, input int step, input int pp_at);
        for (int a = from; a <= to; a += step) begin
            exp_q.push_back({(a == pp_at), 6'(a)});
        end
    endtask

    always begin
        logic [6:0] e;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            check_val("sample_valid", sample_valid, prev_en);
            if (rom_en) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_rom_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rom_addr", rom_addr, e[5:0]);
                    check_val("period_pulse", period_pulse, e[6]);
                end
            end else if (period_pulse) begin
                check_val("stray_period_pulse", 1, 0);
            end
            prev_en = rom_en;
        end
    end

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            check_val("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic load_ftw(input logic [7:0] v);
        @(negedge clk);
        ftw = v;
        ftw_load = 1'b1;
        @(negedge clk);
        ftw_load = 1'b0;
    endtask

    task automatic pulse(input logic s_start, input logic s_stop);
        @(negedge clk);
        start = s_start;
        stop  = s_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic start_measure(input string tag);
        int unsigned n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rom_en && n < 20);
        check_val(tag, n, 4);
        check_val("busy_run", busy, 1);
    endtask

    task automatic expect_idle(input string tag);
        repeat (3) @(posedge clk);
        #2;
        check_val(tag, busy, 0);
        repeat (10) @(posedge clk);
        #2;
        check_val("rom_en_idle", rom_en, 0);
    endtask

    task automatic check_all_zero();
        check_val("rst_rom_en", rom_en, 0);
        check_val("rst_rom_addr", rom_addr, 0);
        check_val("rst_sample_valid", sample_valid, 0);
        check_val("rst_period_pulse", period_pulse, 0);
        check_val("rst_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all_zero();
        @(negedge clk);
        rst_n = 1'b1;

        // Full period at ftw=4, then retune to 8 mid-period at address 10
        load_ftw(8'd4);
        push_range(0, 63, 1, 63);
        push_range(0, 10, 1, -1);
        start_measure("first_latency");
        drain(400);
        load_ftw(8'd8);
        push_range(11, 63, 1, 63);
        push_range(0, 62, 2, 62);
        push_range(0, 2, 2, -1);
        drain(500);

        // start and stop together while running: stop wins
        push_range(4, 62, 2, 62);
        pulse(1'b1, 1'b1);
        drain(300);
        expect_idle("busy_after_stop_same_cycle");

        // stop at address 20 finishes the period
        load_ftw(8'd4);
        push_range(0, 20, 1, -1);
        start_measure("latency_run2");
        drain(200);
        push_range(21, 63, 1, 63);
        pulse(1'b0, 1'b1);
        drain(300);
        expect_idle("busy_after_stop");

        // STOPPING -> RUN via start, then reset mid-run at address 30
        push_range(0, 5, 1, -1);
        start_measure("latency_run3");
        drain(100);
        pulse(1'b0, 1'b1);
        push_range(6, 8, 1, -1);
        drain(100);
        pulse(1'b1, 1'b0);
        push_range(9, 63, 1, 63);
        push_range(0, 30, 1, -1);
        drain(500);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("busy_after_reset");

        // ftw_active was cleared by reset: all addresses 0, stop exits on next tick
        push_range(0, 0, 1, -1);
        push_range(0, 0, 1, -1);
        push_range(0, 0, 1, -1);
        start_measure("latency_ftw0");
        drain(100);
        push_range(0, 0, 1, -1);
        pulse(1'b0, 1'b1);
        drain(50);
        expect_idle("busy_after_ftw0_stop");

        // Restart after reset begins at address 0
        load_ftw(8'd4);
        push_range(0, 5, 1, -1);
        start_measure("latency_restart");
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
